// File: rtl/regfile_op_sequencer.sv
// regfile_op_sequencer: single-command initiator that reads two registers, computes ADD/SUB/AND/LDI
// and writes the result back through a falling-edge-timed write enable.
module regfile_op_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [1:0]            cmd_op_i,
    input  logic [ADDR_WIDTH-1:0] cmd_src_a_i,
    input  logic [ADDR_WIDTH-1:0] cmd_src_b_i,
    input  logic [ADDR_WIDTH-1:0] cmd_dst_i,
    input  logic [DATA_WIDTH-1:0] cmd_imm_i,
    output logic [ADDR_WIDTH-1:0] read_reg1_o,
    output logic [ADDR_WIDTH-1:0] read_reg2_o,
    input  logic [DATA_WIDTH-1:0] read_data1_i,
    input  logic [DATA_WIDTH-1:0] read_data2_i,
    output logic                  reg_write_o,
    output logic [ADDR_WIDTH-1:0] write_reg_no_o,
    output logic [DATA_WIDTH-1:0] write_data_o,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  rsp_zero_o
);
    localparam logic [1:0] OP_ADD = 2'b00, OP_SUB = 2'b01, OP_AND = 2'b10, OP_LDI = 2'b11;
    typedef enum logic [2:0] {IDLE, READ, EXEC, WRITE, RESP} state_e;
    state_e                  state_q, state_d;
    logic                    cmd_ready_q, reg_write_q, accept;
    logic [1:0]              op_q;
    logic [ADDR_WIDTH-1:0]   dst_q, rr1_q, rr2_q, wr_no_q;
    logic [DATA_WIDTH-1:0]   imm_q, a_q, b_q, result_q, result_d;
    assign accept = (state_q == IDLE) && cmd_ready_q && cmd_valid_i;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? ((cmd_op_i == OP_LDI) ? EXEC : READ) : IDLE;
            READ:    state_d = EXEC;
            EXEC:    state_d = WRITE;
            WRITE:   state_d = RESP;
            RESP:    state_d = rsp_ready_i ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        rsp_valid_o = (state_q == RESP);
        rsp_zero_o  = rsp_valid_o && (result_q == '0);
    end
    assign result_d = (op_q == OP_ADD) ? a_q + b_q :
                      (op_q == OP_SUB) ? a_q - b_q :
                      (op_q == OP_AND) ? a_q & b_q : imm_q;
    // cmd_ready is registered so it only rises on the first edge after reset release
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmd_ready_q <= 1'b0;
            op_q        <= '0;
            dst_q       <= '0;
            imm_q       <= '0;
            rr1_q       <= '0;
            rr2_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            wr_no_q     <= '0;
            result_q    <= '0;
        end else begin
            cmd_ready_q <= (state_d == IDLE);
            if (accept) begin
                op_q  <= cmd_op_i;
                dst_q <= cmd_dst_i;
                imm_q <= cmd_imm_i;
                rr1_q <= cmd_src_a_i;
                rr2_q <= cmd_src_b_i;
            end
            if (state_q == READ) begin
                a_q <= read_data1_i;
                b_q <= read_data2_i;
            end
            if (state_q == EXEC) begin
                wr_no_q  <= dst_q;
                result_q <= result_d;
            end
        end
    end
    // Enable spans falling edge to falling edge, so exactly one clock-high phase is gated
    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) reg_write_q <= 1'b0;
        else         reg_write_q <= (state_q == WRITE);
    end
    assign cmd_ready_o    = cmd_ready_q;
    assign read_reg1_o    = rr1_q;
    assign read_reg2_o    = rr2_q;
    assign reg_write_o    = reg_write_q;
    assign write_reg_no_o = wr_no_q;
    assign write_data_o   = result_q;
    assign rsp_data_o     = result_q;
endmodule
